a5_clock_ctrl: RTL and testbench
================================

Name: a5_clock_ctrl

Overview:
- Sequencing controller for the three enable-gated shift registers of the A5/1 keystream generator: 19-bit A, 22-bit B, 23-bit C.
- Each register shifts {so[N-2:0], si} when en=1.
- Drives en_*/si_* through the full run: clear, key load, frame load, majority-clocked mixing, then a handshaked 228-bit keystream.
- Sits between the cipher wrapper (start/key/frame/keystream) and the register instances.

Parameters:
- KEY_LEN, 64, key bits loaded, key[0] first.
- FRAME_LEN, 22, frame-number bits loaded, frame[0] first.
- MIX_CYCLES, 101, majority-clocked cycles before the first keystream bit is presented (100 discarded plus 1 pre-output clock).
- KS_LEN, 228, keystream bits delivered per run.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  run request; accepted only in IDLE.
- key  input  64  session key; sampled on the accepted start.
- frame  input  22  frame number; sampled on the accepted start.
- so_a  input  19  register A contents.
- so_b  input  22  register B contents.
- so_c  input  23  register C contents.
- en_a, en_b, en_c  output  1 each  register shift enables.
- si_a, si_b, si_c  output  1 each  register serial inputs.
- ks_valid  output  1  keystream bit available.
- ks_ready  input  1  consumer accepts the keystream bit.
- ks_bit  output  1  keystream bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last keystream transfer.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter, key and frame latches go to 0.
  - Every output is 0; en_*=0, so the registers hold.
  - Reset mid-run abandons the run with no done pulse.
- Feedback (combinational):
  - fa = so_a[13]^so_a[16]^so_a[17]^so_a[18].
  - fb = so_b[20]^so_b[21].
  - fc = so_c[7]^so_c[20]^so_c[21]^so_c[22].
- Clocking bits and output:
  - Clocking bits: ca=so_a[8], cb=so_b[10], cc=so_c[10].
  - maj = majority(ca,cb,cc).
  - Majority enables: en_x = (cx==maj).
  - ks_bit = so_a[18]^so_b[21]^so_c[22]; driven only in KS, 0 elsewhere.
- en_*/si_* are combinational from state, counter, latches and so_*; the registers act on them at the same edge.
- FSM; cnt is an 8-bit down-counter loaded on each state entry:
  - IDLE: en=0, si=0. On start=1, latch key/frame, cnt=22, go to CLEAR.
  - CLEAR (23 cycles): en_*=1, si_*=0. Zeroes the registers regardless of prior contents.
  - KEY (KEY_LEN cycles, bit index i=0..63): en_*=1.
    - si_a = fa^key[i], si_b = fb^key[i], si_c = fc^key[i].
  - FRAME (FRAME_LEN cycles): same as KEY, using frame[j].
  - MIX (MIX_CYCLES cycles): majority enables; si_x = fx.
  - KS:
    - ks_valid=1.
    - When ks_ready=1: transfer; apply majority enables with si_x=fx; decrement the transfer count.
    - When ks_ready=0: all en=0, ks_bit held stable.
    - After KS_LEN transfers, go to DONE.
  - DONE (1 cycle): done=1, en=0. Then go to IDLE.
- Latency: start accepted at edge E0. CLEAR occupies the 23 cycles after E0, then KEY 64, FRAME 22, MIX 101. ks_valid first rises 210 cycles after E0.
- Keystream bit k (k=0..227) is the output after 101+k majority clocks. The clock on the last transfer is harmless.
- start is ignored while busy=1. start held high in DONE is not accepted until IDLE.
- A change on key/frame after start is accepted has no effect on the run.
- ks_valid never drops while in KS; the bit changes only after a transfer.

Test Plan:
1. key=0, frame=0, ks_ready=1 → registers stay 0 through every load; the first ks_valid comes 210 cycles after start; 228 transfers all with ks_bit=0; done pulses once, 1 cycle after the last transfer; busy falls with done.
2. Registers preloaded nonzero (so_a=19'h7FFFF etc. via a bench model) then start → after CLEAR (23 cycles) all registers read 0; en_*=1, si_*=0 throughout CLEAR.
3. key=64'hEFCDAB8967452312, frame=22'h134 → 228 ks_bit transfers match the bit-exact A5/1 golden model; en_* pattern during MIX matches the model for all 101 cycles.
4. Scenario 3 with ks_ready toggling 1,0,0,1 repeatedly → en_*=0 and ks_bit stable on every ks_ready=0 cycle; the keystream sequence is identical to scenario 3.
5. start pulsed again at cycle 50 and in DONE, with key changed at cycle 5 → no restart, output identical to the original key.
6. rst asserted low during MIX (cycle 150) → all outputs 0 immediately, IDLE, no done. A new start after release produces the full correct run.

Source files
------------

// File: rtl/a5_clock_ctrl.sv
// Sequencing controller for the A5/1 shift registers A/B/C: clear, key load,
// frame load, majority-clocked mixing, then a handshaked keystream.
module a5_clock_ctrl #(
  parameter int KEY_LEN    = 64,
  parameter int FRAME_LEN  = 22,
  parameter int MIX_CYCLES = 101,
  parameter int KS_LEN     = 228
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_LEN-1:0]   key,
  input  logic [FRAME_LEN-1:0] frame,
  input  logic [18:0]          so_a,
  input  logic [21:0]          so_b,
  input  logic [22:0]          so_c,
  output logic                 en_a,
  output logic                 en_b,
  output logic                 en_c,
  output logic                 si_a,
  output logic                 si_b,
  output logic                 si_c,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic                 ks_bit,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_KEY   = 3'd2,
    S_FRAME = 3'd3,
    S_MIX   = 3'd4,
    S_KS    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // CLEAR lasts as long as the longest register so any prior contents flush out.
  localparam logic [7:0] CLEAR_LAST = 8'd22;
  localparam logic [7:0] KEY_LAST   = 8'(KEY_LEN - 1);
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_LEN - 1);
  localparam logic [7:0] MIX_LAST   = 8'(MIX_CYCLES - 1);
  localparam logic [7:0] KS_LAST    = 8'(KS_LEN - 1);

  state_t               state;
  logic [7:0]           cnt;
  logic [KEY_LEN-1:0]   key_q;
  logic [FRAME_LEN-1:0] frame_q;

  logic fa, fb, fc, maj, ma, mb, mc, unused_so;

  assign fa  = so_a[13] ^ so_a[16] ^ so_a[17] ^ so_a[18];
  assign fb  = so_b[20] ^ so_b[21];
  assign fc  = so_c[7] ^ so_c[20] ^ so_c[21] ^ so_c[22];
  assign maj = (so_a[8] & so_b[10]) | (so_a[8] & so_c[10]) | (so_b[10] & so_c[10]);
  assign ma  = (so_a[8] == maj);
  assign mb  = (so_b[10] == maj);
  assign mc  = (so_c[10] == maj);
  assign unused_so = ^{so_a, so_b, so_c};

  assign ks_bit    = (state == S_KS) ? (so_a[18] ^ so_b[21] ^ so_c[22]) : 1'b0;
  assign state_dbg = state;

  // Keystream handshake: a bit transfers on any edge where ks_valid and
  // ks_ready are both high; ks_valid stays high and ks_bit stays stable until
  // that transfer, and the registers only advance on the transfer edge.
  always_comb begin
    en_a = 1'b0;
    en_b = 1'b0;
    en_c = 1'b0;
    si_a = 1'b0;
    si_b = 1'b0;
    si_c = 1'b0;
    case (state)
      S_CLEAR: begin
        en_a = 1'b1;
        en_b = 1'b1;
        en_c = 1'b1;
      end
      S_KEY: begin
        en_a = 1'b1;
        en_b = 1'b1;
        en_c = 1'b1;
        si_a = fa ^ key_q[0];
        si_b = fb ^ key_q[0];
        si_c = fc ^ key_q[0];
      end
      S_FRAME: begin
        en_a = 1'b1;
        en_b = 1'b1;
        en_c = 1'b1;
        si_a = fa ^ frame_q[0];
        si_b = fb ^ frame_q[0];
        si_c = fc ^ frame_q[0];
      end
      S_MIX: begin
        en_a = ma;
        en_b = mb;
        en_c = mc;
        si_a = fa;
        si_b = fb;
        si_c = fc;
      end
      S_KS: begin
        if (ks_ready) begin
          en_a = ma;
          en_b = mb;
          en_c = mc;
          si_a = fa;
          si_b = fb;
          si_c = fc;
        end
      end
      default: ;
    endcase
  end

  // Key and frame latches shift right so the bit in use is always at [0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      key_q    <= '0;
      frame_q  <= '0;
      ks_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_q   <= key;
            frame_q <= frame;
            cnt     <= CLEAR_LAST;
            busy    <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (cnt == 8'd0) begin
            cnt   <= KEY_LAST;
            state <= S_KEY;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_KEY: begin
          key_q <= key_q >> 1;
          if (cnt == 8'd0) begin
            cnt   <= FRAME_LAST;
            state <= S_FRAME;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_FRAME: begin
          frame_q <= frame_q >> 1;
          if (cnt == 8'd0) begin
            cnt   <= MIX_LAST;
            state <= S_MIX;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_MIX: begin
          if (cnt == 8'd0) begin
            cnt      <= KS_LAST;
            ks_valid <= 1'b1;
            state    <= S_KS;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_KS: begin
          if (ks_ready) begin
            if (cnt == 8'd0) begin
              ks_valid <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a5_clock_ctrl.sv
// Directed bench for a5_clock_ctrl: models the three shift registers around the
// controller and checks sequencing, handshake and A5/1 keystream values.
module tb_a5_clock_ctrl;

  localparam logic [63:0] K3 = 64'hEFCDAB8967452312;
  localparam logic [21:0] F3 = 22'h134;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic [21:0] frame = '0;
  logic        ks_ready = 1'b0;
  logic        preload = 1'b0;
  logic [18:0] reg_a;
  logic [21:0] reg_b;
  logic [22:0] reg_c;
  logic        en_a, en_b, en_c, si_a, si_b, si_c;
  logic        ks_valid, ks_bit, busy, done;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [0:0]  exp_q[$];
  logic [0:0]  got_q[$];
  logic [2:0]  exp_en_q[$];
  logic [2:0]  obs_en[256];
  logic [2:0]  obs_si[256];
  logic [63:0] regs_clear, regs_load;
  int          ks_lat, stall_err, stall_cyc, valid_drop;
  logic        done_end, busy_end, valid_end, done_after, busy_after;
  logic        done_after2, busy_after2;

  always #5 clk = ~clk;

  a5_clock_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .frame(frame),
    .so_a(reg_a), .so_b(reg_b), .so_c(reg_c),
    .en_a(en_a), .en_b(en_b), .en_c(en_c),
    .si_a(si_a), .si_b(si_b), .si_c(si_c),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_bit(ks_bit),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // External enable-gated shift registers driven by the controller.
  always @(posedge clk) begin
    if (preload) begin
      reg_a <= 19'h7FFFF;
      reg_b <= 22'h3FFFFF;
      reg_c <= 23'h7FFFFF;
    end else begin
      if (en_a) reg_a <= {reg_a[17:0], si_a};
      if (en_b) reg_b <= {reg_b[20:0], si_b};
      if (en_c) reg_c <= {reg_c[21:0], si_c};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference A5/1: key then frame loading, 101 mixing clocks, then output
  // bit k read after 101+k clocks.
  task automatic gen_golden(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic m, ea, eb, ec;
    a = '0; b = '0; c = '0;
    exp_q.delete();
    exp_en_q.delete();
    for (int i = 0; i < 64; i++) begin
      a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18] ^ k[i]};
      b = {b[20:0], b[20] ^ b[21] ^ k[i]};
      c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22] ^ k[i]};
    end
    for (int j = 0; j < 22; j++) begin
      a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18] ^ f[j]};
      b = {b[20:0], b[20] ^ b[21] ^ f[j]};
      c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22] ^ f[j]};
    end
    for (int i = 0; i < 101 + 228; i++) begin
      if (i >= 101) exp_q.push_back(a[18] ^ b[21] ^ c[22]);
      m  = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
      ea = (a[8] == m);
      eb = (b[10] == m);
      ec = (c[10] == m);
      if (i < 101) exp_en_q.push_back({ea, eb, ec});
      if (ea) a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18]};
      if (eb) b = {b[20:0], b[20] ^ b[21]};
      if (ec) c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22]};
    end
  endtask

  task automatic do_start(input logic [63:0] k, input logic [21:0] f);
    @(negedge clk);
    key = k;
    frame = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the first negedge after the accepting edge (n=0); records
  // observations until ks_valid rises or the cycle budget runs out.
  task automatic wait_ks(input int key_at, input logic [63:0] kx, input int start_at);
    int n;
    n = 0;
    while (n < 400) begin
      if (n == key_at) key = kx;
      if (n == start_at) start = 1'b1;
      else if (n == start_at + 1) start = 1'b0;
      if (n < 256) begin
        obs_en[n] = {en_a, en_b, en_c};
        obs_si[n] = {si_a, si_b, si_c};
      end
      if (n == 23) regs_clear = {reg_a, reg_b, reg_c};
      if (n == 109) regs_load = {reg_a, reg_b, reg_c};
      if (ks_valid) break;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    ks_lat = n;
  endtask

  // Consumes 228 bits; bp selects the ready pattern 1,0,0,1 repeated.
  task automatic collect_ks(input bit bp, input bit poke_done);
    int   cyc;
    bit   new_pos;
    logic hold_bit;
    logic rdy;
    got_q.delete();
    stall_err = 0; stall_cyc = 0; valid_drop = 0;
    cyc = 0; new_pos = 1'b1; hold_bit = 1'b0;
    while (got_q.size() < 228 && cyc < 2000) begin
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      ks_ready = rdy;
      #1;
      if (!ks_valid) valid_drop++;
      if (new_pos) begin
        hold_bit = ks_bit;
        new_pos = 1'b0;
      end
      if (rdy) begin
        got_q.push_back(ks_bit);
        new_pos = 1'b1;
      end else begin
        stall_cyc++;
        if ({en_a, en_b, en_c} !== 3'b000 || ks_bit !== hold_bit) stall_err++;
      end
      @(negedge clk);
      cyc++;
    end
    ks_ready = 1'b0;
    done_end = done; busy_end = busy; valid_end = ks_valid;
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_after = done; busy_after = busy;
    @(negedge clk);
    done_after2 = done; busy_after2 = busy;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({en_a, en_b, en_c, si_a, si_b, si_c, ks_valid, ks_bit, busy, done} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %b want 0", {en_a, en_b, en_c, si_a, si_b, si_c, ks_valid, ks_bit, busy, done});
    end
    n_cmp++;
    if (state_dbg !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state got %0d want 0", state_dbg);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_zero_run;
    do_start(64'd0, 22'd0);
    wait_ks(-1, 64'd0, -1);
    n_cmp++;
    if (ks_lat !== 210) begin
      n_err++;
      $display("FAIL zero_latency got %0d want 210", ks_lat);
    end
    n_cmp++;
    if (regs_load !== 64'd0) begin
      n_err++;
      $display("FAIL zero_regs_after_load got %h want 0", regs_load);
    end
    collect_ks(1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() !== 228) begin
      n_err++;
      $display("FAIL zero_xfer_count got %0d want 228", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== 1'b0) begin
        n_err++;
        $display("FAIL zero_ks[%0d] got %b want 0", i, got_q[i]);
      end
    end
    n_cmp++;
    if ({done_end, busy_end, valid_end} !== 3'b110) begin
      n_err++;
      $display("FAIL zero_done_pulse got %b want 110", {done_end, busy_end, valid_end});
    end
    n_cmp++;
    if ({done_after, busy_after} !== 2'b00) begin
      n_err++;
      $display("FAIL zero_after_done got %b want 00", {done_after, busy_after});
    end
  endtask

  task automatic test_clear;
    gen_golden(K3, F3);
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({reg_a, reg_b, reg_c} !== {64{1'b1}}) begin
      n_err++;
      $display("FAIL idle_hold got %h want all ones", {reg_a, reg_b, reg_c});
    end
    do_start(K3, F3);
    wait_ks(-1, 64'd0, -1);
    for (int n = 0; n < 23; n++) begin
      n_cmp++;
      if ({obs_en[n], obs_si[n]} !== 6'b111000) begin
        n_err++;
        $display("FAIL clear_en_si[%0d] got %b want 111000", n, {obs_en[n], obs_si[n]});
      end
    end
    n_cmp++;
    if (regs_clear !== 64'd0) begin
      n_err++;
      $display("FAIL clear_regs got %h want 0", regs_clear);
    end
    collect_ks(1'b0, 1'b0);
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL clear_ks[%0d] got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_golden;
    logic [31:0] v;
    gen_golden(K3, F3);
    do_start(K3, F3);
    wait_ks(-1, 64'd0, -1);
    n_cmp++;
    if (ks_lat !== 210) begin
      n_err++;
      $display("FAIL gold_latency got %0d want 210", ks_lat);
    end
    for (int m = 0; m < 101; m++) begin
      n_cmp++;
      if (obs_en[109 + m] !== exp_en_q[m]) begin
        n_err++;
        $display("FAIL mix_en[%0d] got %b want %b", m, obs_en[109 + m], exp_en_q[m]);
      end
    end
    collect_ks(1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() !== 228) begin
      n_err++;
      $display("FAIL gold_xfer_count got %0d want 228", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL gold_ks[%0d] got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
    v = '0;
    for (int i = 0; i < 32; i++) v = {v[30:0], got_q[i]};
    n_cmp++;
    if (v !== 32'h534EAA58) begin
      n_err++;
      $display("FAIL gold_vector got %h want 534eaa58", v);
    end
    n_cmp++;
    if ({done_end, done_after, busy_after} !== 3'b100) begin
      n_err++;
      $display("FAIL gold_done got %b want 100", {done_end, done_after, busy_after});
    end
  endtask

  task automatic test_backpressure;
    gen_golden(K3, F3);
    do_start(K3, F3);
    wait_ks(-1, 64'd0, -1);
    collect_ks(1'b1, 1'b0);
    n_cmp++;
    if (stall_err !== 0) begin
      n_err++;
      $display("FAIL bp_stall_behaviour got %0d bad cycles want 0", stall_err);
    end
    n_cmp++;
    if (stall_cyc !== 228) begin
      n_err++;
      $display("FAIL bp_stall_count got %0d want 228", stall_cyc);
    end
    n_cmp++;
    if (valid_drop !== 0) begin
      n_err++;
      $display("FAIL bp_valid_drop got %0d want 0", valid_drop);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_ks[%0d] got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_end !== 1'b1) begin
      n_err++;
      $display("FAIL bp_done got %b want 1", done_end);
    end
  endtask

  task automatic test_restart_ignored;
    gen_golden(K3, F3);
    do_start(K3, F3);
    wait_ks(5, 64'h0011223344556677, 50);
    n_cmp++;
    if (ks_lat !== 210) begin
      n_err++;
      $display("FAIL restart_latency got %0d want 210", ks_lat);
    end
    collect_ks(1'b0, 1'b1);
    n_cmp++;
    if (got_q.size() !== 228) begin
      n_err++;
      $display("FAIL restart_xfer_count got %0d want 228", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL restart_ks[%0d] got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ({busy_after, busy_after2, done_after2} !== 3'b000) begin
      n_err++;
      $display("FAIL restart_in_done got %b want 000", {busy_after, busy_after2, done_after2});
    end
    key = K3;
  endtask

  task automatic test_reset_midrun;
    int done_seen;
    gen_golden(K3, F3);
    do_start(K3, F3);
    repeat (150) @(negedge clk);
    n_cmp++;
    if (state_dbg !== 3'd4) begin
      n_err++;
      $display("FAIL midrun_state_before got %0d want 4", state_dbg);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({en_a, en_b, en_c, si_a, si_b, si_c, ks_valid, ks_bit, busy, done} !== 10'd0) begin
      n_err++;
      $display("FAIL midrun_outputs got %b want 0", {en_a, en_b, en_c, si_a, si_b, si_c, ks_valid, ks_bit, busy, done});
    end
    n_cmp++;
    if (state_dbg !== 3'd0) begin
      n_err++;
      $display("FAIL midrun_state got %0d want 0", state_dbg);
    end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_err++;
      $display("FAIL midrun_no_done got %0d want 0", done_seen);
    end
    do_start(K3, F3);
    wait_ks(-1, 64'd0, -1);
    n_cmp++;
    if (ks_lat !== 210) begin
      n_err++;
      $display("FAIL rerun_latency got %0d want 210", ks_lat);
    end
    collect_ks(1'b0, 1'b0);
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rerun_ks[%0d] got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_end !== 1'b1) begin
      n_err++;
      $display("FAIL rerun_done got %b want 1", done_end);
    end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_clear();
    test_golden();
    test_backpressure();
    test_restart_ignored();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
